// File: rtl/sw_debounce_sync.sv
// sw_debounce_sync: slide-switch conditioning for the CLOCK_50 domain.
// Each raw switch bit passes through a two-flop synchronizer. It then goes
// through an independent stability counter before the clean level changes.
// Rise, fall and any-change pulses are registered on the same edge as the
// clean update.
// Optional build macro: SW_DEBOUNCE_SIM_FAST_EN. When it is defined, the
// stability threshold is forced to 4 cycles so simulations run quickly.
module sw_debounce_sync #(
  parameter int WIDTH   = 10,
  parameter int CNT_MAX = 500000,
  parameter int CNT_W   = 19
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic [WIDTH-1:0] SW_RAW,
  output logic [WIDTH-1:0] SW_CLEAN,
  output logic [WIDTH-1:0] SW_RISE,
  output logic [WIDTH-1:0] SW_FALL,
  output logic             SW_CHANGED,
  output logic             BUSY
);

`ifdef SW_DEBOUNCE_SIM_FAST_EN
  localparam int TH = 4;
`else
  localparam int TH = CNT_MAX;
`endif

  // Terminal count: the clean value flips when the counter has already
  // seen TH-1 differing samples and the current sample still differs.
  localparam logic [CNT_W-1:0] TH_M1 = CNT_W'(TH - 1);

  // A counter that could reach 2^CNT_W would wrap; reject such builds.
  if (CNT_MAX < 1 || longint'(CNT_MAX) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_cnt_max
    $error("sw_debounce_sync: CNT_MAX=%0d outside 1..2^CNT_W-1 (CNT_W=%0d)", CNT_MAX, CNT_W);
  end

  logic [WIDTH-1:0]            sync1_q, sync1_d;
  logic [WIDTH-1:0]            sync2_q, sync2_d;
  logic [WIDTH-1:0]            clean_q, clean_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]            rise_q, rise_d;
  logic [WIDTH-1:0]            fall_q, fall_d;
  logic                        changed_q, changed_d;
  logic                        busy_q, busy_d;

  // Next-state: synchronizer shift, per-bit stability count, edge pulses, busy.
  always_comb begin
    sync1_d = SW_RAW;
    sync2_d = sync1_q;
    clean_d = clean_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] == clean_q[i]) begin
        // Any return to the clean level discards the partial count.
        cnt_d[i] = '0;
      end else if (cnt_q[i] == TH_M1) begin
        clean_d[i] = sync2_q[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
      // Busy reflects counters as they stand before this edge.
      if (cnt_q[i] != '0) begin
        busy_d = 1'b1;
      end
    end
    rise_d    = clean_d & ~clean_q;
    fall_d    = ~clean_d & clean_q;
    changed_d = |(rise_d | fall_d);
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      clean_q   <= '0;
      cnt_q     <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      clean_q   <= clean_d;
      cnt_q     <= cnt_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
      busy_q    <= busy_d;
    end
  end

  assign SW_CLEAN   = clean_q;
  assign SW_RISE    = rise_q;
  assign SW_FALL    = fall_q;
  assign SW_CHANGED = changed_q;
  assign BUSY       = busy_q;

endmodule

// File: tb/tb_sw_debounce_sync.sv
// Bench for sw_debounce_sync. The reference model keeps a history of raw
// samples. A bit's clean level flips once the last TH synchronized samples
// all disagree with it.
module tb_sw_debounce_sync;

  localparam int WIDTH = 10;
  localparam int TH    = 4;
`ifdef SW_DEBOUNCE_SIM_FAST_EN
  localparam int P_CNT_MAX = 500000;
`else
  localparam int P_CNT_MAX = 4;
`endif

  logic             CLOCK_50;
  logic             RESET_N;
  logic [WIDTH-1:0] SW_RAW;
  logic [WIDTH-1:0] SW_CLEAN, SW_RISE, SW_FALL;
  logic             SW_CHANGED, BUSY;

  int n_vec = 0;
  int n_mis = 0;

  sw_debounce_sync #(.WIDTH(WIDTH), .CNT_MAX(P_CNT_MAX), .CNT_W(19)) dut (
    .CLOCK_50  (CLOCK_50),
    .RESET_N   (RESET_N),
    .SW_RAW    (SW_RAW),
    .SW_CLEAN  (SW_CLEAN),
    .SW_RISE   (SW_RISE),
    .SW_FALL   (SW_FALL),
    .SW_CHANGED(SW_CHANGED),
    .BUSY      (BUSY)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: h[s] is the raw value sampled s edges ago (h[0] = this edge).
  // Before edge e, the synchronized value seen by the logic is h[2].
  logic [WIDTH-1:0] h [16];
  logic [WIDTH-1:0] m_clean, m_rise, m_fall, m_new;
  logic             m_chg, m_busy;

  initial begin
    for (int s = 0; s < 16; s++) h[s] = '0;
    m_clean = '0; m_rise = '0; m_fall = '0; m_chg = 1'b0; m_busy = 1'b0;
    forever begin
      @(posedge CLOCK_50 or negedge RESET_N);
      if (!RESET_N) begin
        for (int s = 0; s < 16; s++) h[s] = '0;
        m_clean = '0; m_rise = '0; m_fall = '0; m_chg = 1'b0; m_busy = 1'b0;
      end else begin
        for (int s = 15; s > 0; s--) h[s] = h[s-1];
        h[0] = SW_RAW;
        m_new = m_clean;
        for (int i = 0; i < WIDTH; i++) begin
          logic stable;
          stable = 1'b1;
          for (int s = 2; s <= TH + 1; s++)
            if (h[s][i] == m_clean[i]) stable = 1'b0;
          if (stable) m_new[i] = ~m_clean[i];
        end
        // A counter was running after the previous edge when the synchronized
        // value it saw disagreed with the clean level it left behind.
        m_busy  = |(h[3] ^ m_clean);
        m_rise  = m_new & ~m_clean;
        m_fall  = ~m_new & m_clean;
        m_chg   = |(m_rise | m_fall);
        m_clean = m_new;
      end
      #1;
      chk("clean",   32'(SW_CLEAN),   32'(m_clean));
      chk("rise",    32'(SW_RISE),    32'(m_rise));
      chk("fall",    32'(SW_FALL),    32'(m_fall));
      chk("changed", 32'(SW_CHANGED), 32'(m_chg));
      chk("busy",    32'(BUSY),       32'(m_busy));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLOCK_50);
    #2;
  endtask

  initial begin
    int cnt_a, cnt_b, at;
    logic [WIDTH-1:0] v;
    RESET_N = 1'b1;
    SW_RAW  = '0;
    #1 RESET_N = 1'b0;

    // 1: reset and idle
    step(3);
    RESET_N = 1'b1;
    cnt_a = 0;
    for (int n = 0; n < 20; n++) begin
      step(1);
      if (SW_CLEAN != '0 || SW_RISE != '0 || SW_FALL != '0 || SW_CHANGED || BUSY) cnt_a++;
    end
    chk("idle_quiet", 32'(cnt_a), 32'd0);

    // 2: single bit rise, latency and busy window
    SW_RAW = 10'b0000000001;
    step(1);                               // after edge k
    step(2); chk("t2_busy_k2", 32'(BUSY), 32'd0);
    step(1); chk("t2_busy_k3", 32'(BUSY), 32'd1);
    step(1); chk("t2_clean_k4", 32'(SW_CLEAN), 32'h0);
    step(1);
    chk("t2_clean_k5", 32'(SW_CLEAN), 32'h001);
    chk("t2_rise_k5",  32'(SW_RISE),  32'h001);
    chk("t2_chg_k5",   32'(SW_CHANGED), 32'd1);
    chk("t2_busy_k5",  32'(BUSY), 32'd1);
    step(1);
    chk("t2_rise_k6",  32'(SW_RISE),  32'h000);
    chk("t2_chg_k6",   32'(SW_CHANGED), 32'd0);
    chk("t2_busy_k6",  32'(BUSY), 32'd0);

    // 3: bounce on bit 3
    SW_RAW = '0;
    step(10);
    for (int b = 0; b < 2; b++) begin
      SW_RAW = 10'b0000001000; step(2);
      SW_RAW = 10'b0000000000; step(2);
    end
    SW_RAW = 10'b0000001000;
    cnt_a = 0; cnt_b = 0; at = -1;
    for (int n = 0; n < 12; n++) begin
      step(1);
      if (SW_RISE[3]) begin cnt_a++; at = n; end
      if (SW_FALL != '0) cnt_b++;
    end
    chk("t3_rise_count", 32'(cnt_a), 32'd1);
    chk("t3_rise_edge",  32'(at),    32'd5);
    chk("t3_no_fall",    32'(cnt_b), 32'd0);

    // 4: simultaneous edges
    SW_RAW = 10'b0101110101;
    step(10);
    SW_RAW = 10'b0110111010;
    step(1);
    step(4);
    chk("t4_clean_k4", 32'(SW_CLEAN), 32'(10'b0101110101));
    step(1);
    chk("t4_rise",  32'(SW_RISE),    32'(10'b0010001010));
    chk("t4_fall",  32'(SW_FALL),    32'(10'b0001000101));
    chk("t4_chg",   32'(SW_CHANGED), 32'd1);
    chk("t4_clean", 32'(SW_CLEAN),   32'(10'b0110111010));

    // 5: reset mid-count
    SW_RAW = 10'b1111111111;
    step(2);
    chk("t5_clean_pre", 32'(SW_CLEAN), 32'(10'b0110111010));
    #1 RESET_N = 1'b0;
    #1;
    chk("t5_clean_async", 32'(SW_CLEAN), 32'h0);
    chk("t5_rise_async",  32'(SW_RISE), 32'h0);
    chk("t5_fall_async",  32'(SW_FALL), 32'h0);
    chk("t5_busy_async",  32'({SW_CHANGED, BUSY}), 32'h0);
    SW_RAW = '0;
    step(3);
    #1 RESET_N = 1'b1;
    cnt_a = 0;
    for (int n = 0; n < 20; n++) begin
      step(1);
      if (SW_RISE != '0 || SW_FALL != '0 || SW_CHANGED) cnt_a++;
    end
    chk("t5_no_pulse", 32'(cnt_a), 32'd0);

    // 6: bit 9 at the fast threshold
    SW_RAW = 10'b1000000000;
    step(1);
    step(4);
    chk("t6_clean_k4", 32'(SW_CLEAN), 32'h000);
    step(1);
    chk("t6_clean_k5", 32'(SW_CLEAN), 32'h200);
    chk("t6_rise_k5",  32'(SW_RISE),  32'h200);

    // Random bouncing traffic, one mid-run reset
    v = SW_RAW;
    for (int r = 0; r < 400; r++) begin
      if ($urandom_range(0, 3) == 0) v = WIDTH'($urandom);
      else v = v ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
      SW_RAW = v;
      step(int'($urandom_range(1, 7)));
      if (r == 200) begin
        #1 RESET_N = 1'b0;
        step(2);
        #1 RESET_N = 1'b1;
      end
    end
    step(12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
